// File: rtl/fan_timer_ctrl.sv
// Off-delay fan timer: hour presets, BCD hr:min:sec countdown, pause/resume.
// Optional warn output and WARN_SEC parameter are built with FAN_TIMER_WARN_EN.
module fan_timer_ctrl #(
    parameter int CLK_PER_SEC = 125_000_000,
    parameter int N_PRESET = 4,
    parameter logic [4*N_PRESET-1:0] PRESET_HR = {4'd5, 4'd3, 4'd1, 4'd0}
`ifdef FAN_TIMER_WARN_EN
    ,
    parameter int WARN_SEC = 10
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic timer_en,
    input  logic btn_sel,
    input  logic btn_pause,
    output logic [$clog2(N_PRESET)-1:0] preset_idx,
    output logic [3:0] hr,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic active,
    output logic expired
`ifdef FAN_TIMER_WARN_EN
    ,
    output logic warn
`endif
);

    localparam int IW = $clog2(N_PRESET);
    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_PRESET - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [IW-1:0] idx_nx, sel_idx;
    logic [3:0] hr_nx, sel_hr;
    logic [7:0] min_nx, sec_nx;
    logic active_nx, expired_nx;
    logic run_cycle, tick, last_sec;

    assign sel_idx = (preset_idx == I_LAST) ? '0 : preset_idx + IW'(1);
    assign sel_hr = (sel_idx == '0) ? 4'd0
                  : PRESET_HR[4*int'(sel_idx) +: 4];

    // A resume edge counts as a RUN cycle; a pause edge does not.
    assign run_cycle = (state == RUN && !btn_pause)
                    || (state == PAUSE && btn_pause);
    assign tick = run_cycle && (presc == P_LAST);
    assign last_sec = (hr == 4'd0) && (min == 8'h00) && (sec == 8'h01);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            presc <= '0;
            preset_idx <= '0;
            hr <= '0;
            min <= '0;
            sec <= '0;
            active <= 1'b0;
            expired <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            preset_idx <= idx_nx;
            hr <= hr_nx;
            min <= min_nx;
            sec <= sec_nx;
            active <= active_nx;
            expired <= expired_nx;
        end
    end

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        idx_nx = preset_idx;
        hr_nx = hr;
        min_nx = min;
        sec_nx = sec;
        expired_nx = 1'b0;
        if (!timer_en) begin
            state_nx = IDLE;
            presc_nx = '0;
            idx_nx = '0;
            hr_nx = '0;
            min_nx = '0;
            sec_nx = '0;
        end else if (btn_sel) begin
            idx_nx = sel_idx;
            hr_nx = sel_hr;
            min_nx = 8'h00;
            sec_nx = 8'h00;
            presc_nx = '0;
            state_nx = (sel_hr != 4'd0) ? RUN : IDLE;
        end else begin
            if (btn_pause && state == RUN) state_nx = PAUSE;
            if (btn_pause && state == PAUSE) state_nx = RUN;
            if (run_cycle && !tick) presc_nx = presc + PW'(1);
            if (tick) begin
                presc_nx = '0;
                if (last_sec) begin
                    state_nx = IDLE;
                    idx_nx = '0;
                    sec_nx = 8'h00;
                    expired_nx = 1'b1;
                end else if (sec[3:0] != 4'd0) begin
                    sec_nx = {sec[7:4], sec[3:0] - 4'd1};
                end else if (sec[7:4] != 4'd0) begin
                    sec_nx = {sec[7:4] - 4'd1, 4'd9};
                end else begin
                    sec_nx = 8'h59;
                    if (min[3:0] != 4'd0) begin
                        min_nx = {min[7:4], min[3:0] - 4'd1};
                    end else if (min[7:4] != 4'd0) begin
                        min_nx = {min[7:4] - 4'd1, 4'd9};
                    end else begin
                        min_nx = 8'h59;
                        hr_nx = hr - 4'd1;
                    end
                end
            end
        end
        active_nx = (state_nx != IDLE);
    end

`ifdef FAN_TIMER_WARN_EN
    // BCD order matches numeric order, so the compare works on raw digits.
    localparam logic [7:0] WARN_BCD = {4'(WARN_SEC / 10), 4'(WARN_SEC % 10)};
    logic warn_nx;

    assign warn_nx = active_nx && (hr_nx == 4'd0) && (min_nx == 8'h00)
                  && (sec_nx <= WARN_BCD);

    always_ff @(posedge clk) begin
        if (!reset_n) warn <= 1'b0;
        else warn <= warn_nx;
    end
`endif

endmodule

// File: tb/tb_fan_timer_ctrl.sv
// Directed bench for fan_timer_ctrl with CLK_PER_SEC=4 and a scoreboard queue.
// Covers warn as well when FAN_TIMER_WARN_EN is defined.
module tb_fan_timer_ctrl;

    logic clk = 1'b0;
    logic reset_n, timer_en, btn_sel, btn_pause;
    logic [1:0] preset_idx;
    logic [3:0] hr;
    logic [7:0] min, sec;
    logic active, expired, warn;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        logic [24:0] v;
    } exp_t;

    exp_t q[$];
    logic [24:0] obs;

`ifdef FAN_TIMER_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
    assign warn = 1'b0;
`endif

    fan_timer_ctrl #(
        .CLK_PER_SEC(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .timer_en(timer_en),
        .btn_sel(btn_sel),
        .btn_pause(btn_pause),
        .preset_idx(preset_idx),
        .hr(hr),
        .min(min),
        .sec(sec),
        .active(active),
        .expired(expired)
`ifdef FAN_TIMER_WARN_EN
        ,
        .warn(warn)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {preset_idx, hr, min, sec, active, expired, warn};

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [24:0] mk(input int idx, input int h,
                                       input int m, input int s,
                                       input bit a, input bit e,
                                       input bit w);
        return {2'(idx), 4'(h), bcd(m), bcd(s), a, e, w & WARN_ON};
    endfunction

    task automatic cyc(input string tag, input logic [24:0] e);
        exp_t x;
        x.tag = tag;
        x.v = e;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        checks++;
        assert (obs === x.v)
        else begin
            errors++;
            $error("FAIL %s got %h want %h", x.tag, obs, x.v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] zero, e;
        int rem;
        zero = mk(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        timer_en = 1'b1;
        btn_sel = 1'b0;
        btn_pause = 1'b0;
        cyc("reset0", zero);
        cyc("reset1", zero);
        reset_n = 1'b1;

        // load preset 1 and see the first tick after 4 cycles
        btn_sel = 1'b1;
        cyc("load", mk(1, 1, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        for (int k = 1; k < 4; k++) cyc("hold", mk(1, 1, 0, 0, 1, 0, 0));
        cyc("tick1", mk(1, 0, 59, 59, 1, 0, 0));

        // reset while running
        reset_n = 1'b0;
        cyc("rst_run0", zero);
        cyc("rst_run1", zero);
        reset_n = 1'b1;
        cyc("rst_after", zero);

        // preset wrap
        btn_sel = 1'b1;
        cyc("wrap1", mk(1, 1, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        idle(9);
        btn_sel = 1'b1;
        cyc("wrap2", mk(2, 3, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        idle(9);
        btn_sel = 1'b1;
        cyc("wrap3", mk(3, 5, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        idle(9);
        btn_sel = 1'b1;
        cyc("wrap0", zero);
        btn_sel = 1'b0;
        cyc("wrap0_hold", zero);

        // pause with prescaler at 1, resume, then sel+pause together
        btn_sel = 1'b1;
        cyc("p_load", mk(1, 1, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        idle(5);
        e = mk(1, 0, 59, 59, 1, 0, 0);
        btn_pause = 1'b1;
        cyc("pause", e);
        btn_pause = 1'b0;
        for (int k = 0; k < 20; k++) cyc("frozen", e);
        btn_pause = 1'b1;
        cyc("resume", e);
        btn_pause = 1'b0;
        cyc("resume1", e);
        cyc("resume_tick", mk(1, 0, 59, 58, 1, 0, 0));
        btn_sel = 1'b1;
        btn_pause = 1'b1;
        cyc("sel_pause", mk(2, 3, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        btn_pause = 1'b0;
        idle(3);
        cyc("sel_pause_run", mk(2, 2, 59, 59, 1, 0, 0));

        // full countdown of preset 1
        btn_sel = 1'b1;
        cyc("x_sel3", mk(3, 5, 0, 0, 1, 0, 0));
        cyc("x_sel0", zero);
        cyc("x_load", mk(1, 1, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        for (int k = 1; k < 14400; k++) begin
            rem = 3600 - k / 4;
            cyc("count", mk(1, rem / 3600, (rem / 60) % 60, rem % 60,
                            1, 0, (rem <= 10)));
        end
        cyc("expire", mk(0, 0, 0, 0, 0, 1, 0));
        cyc("expire_after", zero);

        // enable drop
        btn_sel = 1'b1;
        cyc("en_load", mk(1, 1, 0, 0, 1, 0, 0));
        cyc("en_load2", mk(2, 3, 0, 0, 1, 0, 0));
        btn_sel = 1'b0;
        idle(2);
        timer_en = 1'b0;
        cyc("en_low", zero);
        btn_sel = 1'b1;
        cyc("en_low_sel", zero);
        btn_sel = 1'b0;
        timer_en = 1'b1;
        cyc("en_high", zero);
        cyc("en_high2", zero);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
